// File: rtl/reg_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reg_access_ctrl_pkg
// Shared definitions for the register access controller: request opcodes,
// FSM state encodings and a small opcode helper.
// -----------------------------------------------------------------------------
package reg_access_ctrl_pkg;

    // Request opcodes carried on req_op
    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_WVERIFY = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    // Controller states; the register strobes are decoded directly from these
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_READ  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    // True for ops that start with a register write
    function automatic logic op_writes(input op_e op);
        return (op == OP_WRITE) || (op == OP_WVERIFY);
    endfunction

endpackage

// File: rtl/reg_access_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// reg_access_ctrl_sat_counter
// Saturating up-counter: increments on inc, holds once it reaches all-ones.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset (clears count)
//   inc   in   increment request
//   count out  current count value
// -----------------------------------------------------------------------------
module reg_access_ctrl_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/reg_access_ctrl.sv
// -----------------------------------------------------------------------------
// reg_access_ctrl
// Sequencer in front of a single-register storage stage. Accepts WRITE, READ
// and WRITE_VERIFY requests on a valid/ready channel, drives the register's
// write and read strobes one at a time, and returns the result on a
// valid/ready response channel. Keeps a wrapping transaction counter and a
// saturating error counter.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready/req_op/req_data request channel
//   resp_valid/resp_ready/resp_data/resp_err  response channel
//   reg_write_data/reg_write_enable/reg_read_enable/reg_read_data
//                                       register storage stage interface
//   txn_count, err_count                status counters
// -----------------------------------------------------------------------------
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    output logic                  reg_write_enable,
    output logic                  reg_read_enable,
    input  logic [DATA_WIDTH-1:0] reg_read_data,
    output logic [CNT_WIDTH-1:0]  txn_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    state_e                state_q;
    op_e                   op_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_err_q;
    logic [CNT_WIDTH-1:0]  txn_count_q;
    logic [CNT_WIDTH-1:0]  txn_count_d;
    logic                  resp_hs;
    op_e                   req_op_e;

    assign req_op_e = op_e'(req_op);
    assign resp_hs  = (state_q == S_RESP) && resp_ready;

    // Controller FSM. Latched write data doubles as reg_write_data so the
    // register sees a stable value for the whole write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op_e;
                        wdata_q <= req_data;
                        if (op_writes(req_op_e)) begin
                            state_q <= S_WRITE;
                        end else if (req_op_e == OP_READ) begin
                            state_q <= S_READ;
                        end else begin
                            // Illegal op: respond immediately, no register access
                            state_q     <= S_RESP;
                            resp_data_q <= req_data;
                            resp_err_q  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (op_q == OP_WVERIFY) begin
                        state_q <= S_READ;
                    end else begin
                        state_q     <= S_RESP;
                        resp_data_q <= wdata_q;
                        resp_err_q  <= 1'b0;
                    end
                end
                S_READ: begin
                    // Register read data is valid during the read-strobe cycle
                    state_q     <= S_RESP;
                    resp_data_q <= reg_read_data;
                    resp_err_q  <= (op_q == OP_WVERIFY) && (reg_read_data != wdata_q);
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes come straight from the state register: they are mutually
    // exclusive by construction and drop as soon as reset asserts.
    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign reg_write_enable = (state_q == S_WRITE);
    assign reg_read_enable  = (state_q == S_READ);
    assign reg_write_data   = wdata_q;
    assign resp_data        = resp_data_q;
    assign resp_err         = resp_err_q;

    // Completed-transaction counter, wraps naturally
    always_comb begin
        txn_count_d = txn_count_q;
        if (resp_hs) begin
            txn_count_d = txn_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    assign txn_count = txn_count_q;

    reg_access_ctrl_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resp_hs && resp_err_q),
        .count (err_count)
    );

endmodule

// File: tb/tb_reg_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_access_ctrl
// Drives reg_access_ctrl against a behavioural model of the single-register
// storage stage. Expected responses go into a queue when a request is issued
// and are popped and compared when the response handshake completes.
// -----------------------------------------------------------------------------
module tb_reg_access_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        bit         chk_data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_err;
    logic [7:0] reg_write_data;
    logic       reg_write_enable;
    logic       reg_read_enable;
    logic [7:0] reg_read_data;
    logic [7:0] txn_count;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;
    int exp_txn  = 0;
    int exp_err  = 0;
    exp_t sb[$];

    // Register storage stage model plus an override for error injection
    logic [7:0] reg_mem;
    logic       force_rd;
    logic [7:0] force_val;

    always @(posedge clk) if (reg_write_enable) reg_mem <= reg_write_data;
    assign reg_read_data = force_rd ? force_val :
                           ((reg_read_enable && !reg_write_enable) ? reg_mem : 8'h00);

    reg_access_ctrl #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_err         (resp_err),
        .reg_write_data   (reg_write_data),
        .reg_write_enable (reg_write_enable),
        .reg_read_enable  (reg_read_enable),
        .reg_read_data    (reg_read_data),
        .txn_count        (txn_count),
        .err_count        (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: exclusivity and single-cycle pulses on every cycle
    int   cyc = 0;
    int   we_cnt = 0, re_cnt = 0, we_cyc = 0, re_cyc = 0;
    logic we_prev = 1'b0, re_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            we_prev = 1'b0;
            re_prev = 1'b0;
        end else begin
            checks++;
            if (reg_write_enable && reg_read_enable) begin
                failures++;
                $display("FAIL strobe_exclusive cyc=%0d we=%0b re=%0b required not both high",
                         cyc, reg_write_enable, reg_read_enable);
            end
            checks++;
            if ((reg_write_enable && we_prev) || (reg_read_enable && re_prev)) begin
                failures++;
                $display("FAIL strobe_width cyc=%0d we=%0b re=%0b required single-cycle pulses",
                         cyc, reg_write_enable, reg_read_enable);
            end
            if (reg_write_enable) begin we_cnt++; we_cyc = cyc; end
            if (reg_read_enable)  begin re_cnt++; re_cyc = cyc; end
            we_prev = reg_write_enable;
            re_prev = reg_read_enable;
        end
    end

    // One request/response exchange. Returns the observed response and the
    // latency (edges from acceptance to resp_valid visible; 0 on timeout).
    task automatic do_txn(input logic [1:0] op, input logic [7:0] d,
                          output logic [7:0] rd, output logic re, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = 8'($urandom);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            if (resp_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        rd = resp_data;
        re = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        $display("txn op=%0d wdata=%02h rdata=%02h err=%0b lat=%0d txn_count=%0d err_count=%0d",
                 op, d, rd, re, lat, txn_count, err_count);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic       re;
        int         lat;
        exp_t       e;
        bit         bad;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || reg_write_enable !== 1'b0 || reg_read_enable !== 1'b0 ||
            resp_data !== 8'h00 || resp_err !== 1'b0 || reg_write_data !== 8'h00 ||
            txn_count !== 8'h00 || err_count !== 8'h00) begin
            failures++;
            $display("FAIL reset_state vld=%0b we=%0b re=%0b data=%02h err=%0b wd=%02h txn=%02h errc=%02h required all zero",
                     resp_valid, reg_write_enable, reg_read_enable, resp_data, resp_err,
                     reg_write_data, txn_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%0b required=1", req_ready);
        end
        // One completed write so the counters have something to clear
        sb.push_back('{data: 8'h11, err: 1'b0, lat: 2, chk_data: 1'b1});
        do_txn(2'b00, 8'h11, rd, re, lat);
        e = sb.pop_front();
        exp_txn++;
        checks++;
        if (rd !== e.data || re !== e.err || lat != e.lat || txn_count !== 8'(exp_txn)) begin
            failures++;
            $display("FAIL reset_pre_write data=%02h err=%0b lat=%0d txn=%0d required %02h/%0b/%0d/%0d",
                     rd, re, lat, txn_count, e.data, e.err, e.lat, exp_txn);
        end
        // Start a WRITE_VERIFY and pull reset while the write strobe is up
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_data  = 8'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (reg_write_enable !== 1'b1) begin
            failures++;
            $display("FAIL reset_midop_we_before got=%0b required=1", reg_write_enable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reg_write_enable !== 1'b0 || reg_read_enable !== 1'b0 || resp_valid !== 1'b0 ||
            txn_count !== 8'h00 || err_count !== 8'h00) begin
            failures++;
            $display("FAIL reset_midop we=%0b re=%0b vld=%0b txn=%02h errc=%02h required all zero",
                     reg_write_enable, reg_read_enable, resp_valid, txn_count, err_count);
        end
        exp_txn = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || reg_write_enable !== 1'b0 ||
                reg_read_enable !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_abandon vld=%0b we=%0b re=%0b rdy=%0b required idle with no response",
                     resp_valid, reg_write_enable, reg_read_enable, req_ready);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        logic       re;
        int         lat;
        exp_t       e;
        sb.push_back('{data: 8'hA5, err: 1'b0, lat: 2, chk_data: 1'b1});
        do_txn(2'b00, 8'hA5, rd, re, lat);
        e = sb.pop_front();
        exp_txn++;
        checks++;
        if (rd !== e.data || re !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL write_a5 data=%02h err=%0b lat=%0d required %02h/%0b/%0d",
                     rd, re, lat, e.data, e.err, e.lat);
        end
        sb.push_back('{data: 8'hA5, err: 1'b0, lat: 2, chk_data: 1'b1});
        do_txn(2'b01, 8'h00, rd, re, lat);
        e = sb.pop_front();
        exp_txn++;
        checks++;
        if (rd !== e.data || re !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL read_a5 data=%02h err=%0b lat=%0d required %02h/%0b/%0d",
                     rd, re, lat, e.data, e.err, e.lat);
        end
        checks++;
        if (txn_count !== 8'(exp_txn)) begin
            failures++;
            $display("FAIL write_read_txn_count got=%0d required=%0d", txn_count, exp_txn);
        end
    endtask

    task automatic test_verify();
        logic [7:0] rd;
        logic       re;
        int         lat;
        exp_t       e;
        we_cnt = 0;
        re_cnt = 0;
        sb.push_back('{data: 8'h3C, err: 1'b0, lat: 3, chk_data: 1'b1});
        do_txn(2'b10, 8'h3C, rd, re, lat);
        e = sb.pop_front();
        exp_txn++;
        checks++;
        if (rd !== e.data || re !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL verify_ok data=%02h err=%0b lat=%0d required %02h/%0b/%0d",
                     rd, re, lat, e.data, e.err, e.lat);
        end
        checks++;
        if (we_cnt != 1 || re_cnt != 1 || re_cyc != we_cyc + 1) begin
            failures++;
            $display("FAIL verify_strobes we_cnt=%0d re_cnt=%0d we_cyc=%0d re_cyc=%0d required 1/1 with read right after write",
                     we_cnt, re_cnt, we_cyc, re_cyc);
        end
        force_val = 8'h3D;
        force_rd  = 1'b1;
        sb.push_back('{data: 8'h3D, err: 1'b1, lat: 3, chk_data: 1'b1});
        do_txn(2'b10, 8'h3C, rd, re, lat);
        force_rd = 1'b0;
        e = sb.pop_front();
        exp_txn++;
        exp_err++;
        checks++;
        if (rd !== e.data || re !== e.err || lat != e.lat) begin
            failures++;
            $display("FAIL verify_mismatch data=%02h err=%0b lat=%0d required %02h/%0b/%0d",
                     rd, re, lat, e.data, e.err, e.lat);
        end
        checks++;
        if (err_count !== 8'(exp_err) || txn_count !== 8'(exp_txn)) begin
            failures++;
            $display("FAIL verify_counters err_count=%0d txn_count=%0d required %0d/%0d",
                     err_count, txn_count, exp_err, exp_txn);
        end
    endtask

    task automatic test_illegal_hold();
        logic [7:0] d0;
        bit         bad;
        exp_t       e;
        we_cnt = 0;
        re_cnt = 0;
        sb.push_back('{data: 8'h00, err: 1'b1, lat: 1, chk_data: 1'b0});
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_data  = 8'hC7;
        @(posedge clk);
        #1;
        // A READ arrives while the response is pending; it must stall
        req_op = 2'b01;
        e = sb.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== e.err) begin
            failures++;
            $display("FAIL illegal_resp vld=%0b err=%0b required 1/%0b at latency %0d",
                     resp_valid, resp_err, e.err, e.lat);
        end
        d0  = resp_data;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) req_valid = 1'b0;
            if (resp_valid !== 1'b1 || resp_data !== d0 || resp_err !== 1'b1 || req_ready !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL illegal_hold vld=%0b data=%02h err=%0b rdy=%0b required 1/%02h/1/0",
                     resp_valid, resp_data, resp_err, req_ready, d0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        exp_txn++;
        exp_err++;
        $display("txn op=3 wdata=c7 rdata=%02h err=1 lat=1 txn_count=%0d err_count=%0d",
                 d0, txn_count, err_count);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_cnt != 0 || re_cnt != 0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_no_access we_cnt=%0d re_cnt=%0d vld=%0b required 0/0/0",
                     we_cnt, re_cnt, resp_valid);
        end
        checks++;
        if (txn_count !== 8'(exp_txn) || err_count !== 8'(exp_err)) begin
            failures++;
            $display("FAIL illegal_counters txn=%0d err=%0d required %0d/%0d",
                     txn_count, err_count, exp_txn, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic       re;
        int         lat;
        exp_t       e;
        logic [7:0] d;
        // resp_ready high with nothing pending must not move the counters
        resp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checks++;
        if (txn_count !== 8'(exp_txn) || err_count !== 8'(exp_err) || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_resp_ready txn=%0d err=%0d vld=%0b required %0d/%0d/0",
                     txn_count, err_count, resp_valid, exp_txn, exp_err);
        end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            sb.push_back('{data: d, err: 1'b0, lat: 2, chk_data: 1'b1});
            sb.push_back('{data: d, err: 1'b0, lat: 2, chk_data: 1'b1});
            do_txn(2'b00, d, rd, re, lat);
            e = sb.pop_front();
            exp_txn++;
            checks++;
            if (rd !== e.data || re !== e.err || lat != e.lat || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_write data=%02h err=%0b lat=%0d rdy=%0b required %02h/%0b/%0d/1",
                         rd, re, lat, req_ready, e.data, e.err, e.lat);
            end
            do_txn(2'b01, 8'h00, rd, re, lat);
            e = sb.pop_front();
            exp_txn++;
            checks++;
            if (rd !== e.data || re !== e.err || lat != e.lat || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_read data=%02h err=%0b lat=%0d rdy=%0b required %02h/%0b/%0d/1",
                         rd, re, lat, req_ready, e.data, e.err, e.lat);
            end
        end
    endtask

    task automatic test_counters();
        logic [7:0] rd;
        logic       re;
        int         lat;
        exp_t       e;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            sb.push_back('{data: d, err: 1'b0, lat: 2, chk_data: 1'b1});
            do_txn(2'b00, d, rd, re, lat);
            e = sb.pop_front();
            exp_txn++;
            checks++;
            if (rd !== e.data || re !== e.err || lat != e.lat) begin
                failures++;
                $display("FAIL cnt_write i=%0d data=%02h err=%0b lat=%0d required %02h/%0b/%0d",
                         i, rd, re, lat, e.data, e.err, e.lat);
            end
            if ((exp_txn % 256) == 0) begin
                checks++;
                if (txn_count !== 8'h00) begin
                    failures++;
                    $display("FAIL txn_wrap got=%02h required=00", txn_count);
                end
            end
        end
        checks++;
        if (txn_count !== 8'(exp_txn)) begin
            failures++;
            $display("FAIL txn_after_256 got=%0d required=%0d", txn_count, exp_txn % 256);
        end
        for (int i = 0; i < 300; i++) begin
            sb.push_back('{data: 8'h00, err: 1'b1, lat: 1, chk_data: 1'b0});
            do_txn(2'b11, 8'(i), rd, re, lat);
            e = sb.pop_front();
            exp_txn++;
            if (exp_err < 255) exp_err++;
            checks++;
            if (re !== e.err || lat != e.lat || err_count !== 8'(exp_err)) begin
                failures++;
                $display("FAIL cnt_illegal i=%0d err=%0b lat=%0d err_count=%02h required %0b/%0d/%02h",
                         i, re, lat, err_count, e.err, e.lat, exp_err);
            end
        end
        checks++;
        if (err_count !== 8'hFF || txn_count !== 8'(exp_txn)) begin
            failures++;
            $display("FAIL err_saturate err_count=%02h txn=%0d required ff/%0d",
                     err_count, txn_count, exp_txn % 256);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_data   = 8'h00;
        resp_ready = 1'b0;
        force_rd   = 1'b0;
        force_val  = 8'h00;
        test_reset();
        test_write_read();
        test_verify();
        test_illegal_hold();
        test_back_to_back();
        test_counters();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at %0t required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
